// File: rtl/widths_union_pkg.sv
// Shared types for the word-to-byte scheduler: the word/byte overlay union,
// the FSM state encoding and the word/byte widths.
package widths_union_pkg;

    localparam int WU_WORD_W = 16;
    localparam int WU_BYTE_W = 8;

    typedef union packed {
        logic [WU_WORD_W-1:0] w;
        struct packed {
            logic [WU_BYTE_W-1:0] hi;
            logic [WU_BYTE_W-1:0] lo;
        } b;
    } wu_word_t;

    typedef enum logic [1:0] {
        WU_IDLE,
        WU_BYTE0,
        WU_BYTE1
    } wu_state_t;

endpackage

// File: rtl/widths_union_mod.sv
// Byte splitter: views a 16-bit word through the packed union and exposes its
// low and high bytes.
module widths_union_mod
    import widths_union_pkg::*;
(
    input  logic [WU_WORD_W-1:0] u_in,
    output logic [WU_BYTE_W-1:0] u_low,
    output logic [WU_BYTE_W-1:0] u_high
);

    wu_word_t word;

    assign word   = u_in;
    assign u_low  = word.b.lo;
    assign u_high = word.b.hi;

endmodule

// File: rtl/widths_union_byte_sched.sv
// Round-robin word-to-byte scheduler: grants one 16-bit requester at a time and
// streams its two bytes out. Define WIDTHS_UNION_HIGH_FIRST_EN to send the high byte first.
module widths_union_byte_sched
    import widths_union_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WU_WORD_W-1:0] req_word,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WU_BYTE_W-1:0]         out_byte,
    output logic                         out_last,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    output logic                         busy,
    output logic [CNT_W-1:0]             byte_count
);

    localparam int SRC_W = $clog2(NUM_REQ);

    wu_state_t          state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   src_q, src_d;
    wu_word_t           word_q, word_d;
    logic [CNT_W-1:0]   byte_count_q, byte_count_d;
    logic [SRC_W-1:0]   grant, grant_next;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [WU_BYTE_W-1:0] u_low, u_high, first_byte, second_byte;
    logic               handshake;

    // First valid requester at or after ptr, wrapping around.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SRC_W-1:0]   ptr);
        logic [SRC_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[SRC_W'(idx)]) begin
                found = 1'b1;
                pick  = SRC_W'(idx);
            end
        end
        return pick;
    endfunction

    assign grant      = rr_pick(req_valid, rr_ptr_q);
    assign grant_next = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    widths_union_mod u_split (
        .u_in   (word_q.w),
        .u_low  (u_low),
        .u_high (u_high)
    );

`ifdef WIDTHS_UNION_HIGH_FIRST_EN
    assign first_byte  = u_high;
    assign second_byte = u_low;
`else
    assign first_byte  = u_low;
    assign second_byte = u_high;
`endif

    assign out_valid  = (state_q != WU_IDLE);
    assign busy       = (state_q != WU_IDLE);
    assign out_last   = (state_q == WU_BYTE1);
    assign out_src    = src_q;
    assign byte_count = byte_count_q;
    assign handshake  = out_valid & out_ready;

    // The accept strobe is combinational, so it must be masked while reset is held.
    assign req_ready  = req_ready_c & {NUM_REQ{rst_n}};

    always_comb begin
        case (state_q)
            WU_BYTE0: out_byte = first_byte;
            WU_BYTE1: out_byte = second_byte;
            default:  out_byte = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WU_IDLE;
            rr_ptr_q     <= '0;
            word_q       <= '0;
            src_q        <= '0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            word_q       <= word_d;
            src_q        <= src_d;
            byte_count_q <= byte_count_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        word_d       = word_q;
        src_d        = src_q;
        byte_count_d = byte_count_q;
        req_ready_c  = '0;

        case (state_q)
            WU_IDLE: begin
                if (|req_valid) begin
                    req_ready_c[grant] = 1'b1;
                    word_d.w = req_word[int'(grant)*WU_WORD_W +: WU_WORD_W];
                    src_d    = grant;
                    rr_ptr_d = grant_next;
                    state_d  = WU_BYTE0;
                end
            end
            WU_BYTE0: if (out_ready) state_d = WU_BYTE1;
            WU_BYTE1: if (out_ready) state_d = WU_IDLE;
            default:  state_d = WU_IDLE;
        endcase

        if (handshake) byte_count_d = byte_count_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_widths_union_byte_sched.sv
// Self-checking bench for widths_union_byte_sched (NUM_REQ=2): table of single
// words, then backpressure, reset mid-word, contention, counter wrap and idle.
module tb_widths_union_byte_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req_word;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [0:0]  out_src;
    logic        busy;
    logic [15:0] byte_count;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt;
    logic [1:0]  pend_q;

    typedef struct {
        logic [1:0]  rv;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [1:0]  exp_ready;
        logic        exp_src;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;

    vec_t vecs[5];

    widths_union_byte_sched #(.NUM_REQ(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_word   (req_word),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .out_src    (out_src),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // Requesters must keep req_valid up until they have seen req_ready.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++)
                if (pend_q[i] && !req_valid[i])
                    $error("protocol: requester %0d dropped req_valid early", i);
            pend_q <= req_valid & ~req_ready;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] first_b(input logic [7:0] lo, input logic [7:0] hi);
`ifdef WIDTHS_UNION_HIGH_FIRST_EN
        return hi;
`else
        return lo;
`endif
    endfunction

    function automatic logic [7:0] second_b(input logic [7:0] lo, input logic [7:0] hi);
`ifdef WIDTHS_UNION_HIGH_FIRST_EN
        return lo;
`else
        return hi;
`endif
    endfunction

    // One uncontended word with out_ready=1; starts and ends in IDLE.
    task automatic run_word(input vec_t v, input string tag);
        @(negedge clk);
        req_valid = v.rv;
        req_word  = {v.w1, v.w0};
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(v.exp_ready));
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check({tag, " b0 valid"}, 32'(out_valid), 32'd1);
        check({tag, " b0 byte"}, 32'(out_byte), 32'(first_b(v.exp_lo, v.exp_hi)));
        check({tag, " b0 last"}, 32'(out_last), 32'd0);
        check({tag, " src"}, 32'(out_src), 32'(v.exp_src));
        @(negedge clk);
        #1;
        check({tag, " b1 byte"}, 32'(out_byte), 32'(second_b(v.exp_lo, v.exp_hi)));
        check({tag, " b1 last"}, 32'(out_last), 32'd1);
        check({tag, " cnt mid"}, 32'(byte_count), 32'(16'(exp_cnt + 16'd1)));
        @(negedge clk);
        #1;
        exp_cnt = exp_cnt + 16'd2;
        check({tag, " end valid"}, 32'(out_valid), 32'd0);
        check({tag, " cnt end"}, 32'(byte_count), 32'(exp_cnt));
    endtask

    initial begin
        vec_t bp;
        vec_t wr;
        // rr_ptr starts at 0 and advances to grant+1 after each grant.
        vecs[0] = '{rv: 2'b01, w0: 16'hA55A, w1: 16'h0000, exp_ready: 2'b01, exp_src: 1'b0, exp_lo: 8'h5A, exp_hi: 8'hA5};
        vecs[1] = '{rv: 2'b10, w0: 16'h0000, w1: 16'hBEEF, exp_ready: 2'b10, exp_src: 1'b1, exp_lo: 8'hEF, exp_hi: 8'hBE};
        vecs[2] = '{rv: 2'b10, w0: 16'h0000, w1: 16'h0001, exp_ready: 2'b10, exp_src: 1'b1, exp_lo: 8'h01, exp_hi: 8'h00};
        vecs[3] = '{rv: 2'b01, w0: 16'hFF00, w1: 16'h0000, exp_ready: 2'b01, exp_src: 1'b0, exp_lo: 8'h00, exp_hi: 8'hFF};
        vecs[4] = '{rv: 2'b01, w0: 16'h8001, w1: 16'hFFFF, exp_ready: 2'b01, exp_src: 1'b0, exp_lo: 8'h01, exp_hi: 8'h80};
        bp      = '{rv: 2'b01, w0: 16'hC3D2, w1: 16'h0000, exp_ready: 2'b01, exp_src: 1'b0, exp_lo: 8'hD2, exp_hi: 8'hC3};
        wr      = '{rv: 2'b10, w0: 16'h0000, w1: 16'h1234, exp_ready: 2'b10, exp_src: 1'b1, exp_lo: 8'h34, exp_hi: 8'h12};

        // Reset state, including a request arriving while reset is held.
        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_word  = 32'h0000_A55A;
        out_ready = 1'b1;
        exp_cnt   = 16'd0;
        #2;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst out_byte", 32'(out_byte), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst out_src", 32'(out_src), 32'd0);
        check("rst byte_count", 32'(byte_count), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_word(vecs[i], $sformatf("vec%0d", i));

        // Backpressure in BYTE0: rr_ptr=1, only requester 0 valid.
        @(negedge clk);
        req_valid = bp.rv;
        req_word  = {bp.w1, bp.w0};
        #1;
        check("bp ready", 32'(req_ready), 32'(bp.exp_ready));
        @(negedge clk);
        req_valid = 2'b00;
        out_ready = 1'b0;
        #1;
        check("bp first byte", 32'(out_byte), 32'(first_b(bp.exp_lo, bp.exp_hi)));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold byte", 32'(out_byte), 32'(first_b(bp.exp_lo, bp.exp_hi)));
            check("bp hold last", 32'(out_last), 32'd0);
            check("bp hold src", 32'(out_src), 32'd0);
            check("bp hold cnt", 32'(byte_count), 32'(exp_cnt));
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp b1 byte", 32'(out_byte), 32'(second_b(bp.exp_lo, bp.exp_hi)));
        check("bp b1 last", 32'(out_last), 32'd1);
        @(negedge clk);
        #1;
        exp_cnt = exp_cnt + 16'd2;
        check("bp done valid", 32'(out_valid), 32'd0);
        check("bp done cnt", 32'(byte_count), 32'(exp_cnt));

        // Reset mid-word: requester 0 granted leaves rr_ptr=1 before reset.
        @(negedge clk);
        req_valid = 2'b01;
        req_word  = 32'h0000_7788;
        #1;
        check("mid ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check("mid in byte1", 32'(out_last), 32'd1);
        #1;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_word  = 32'h3344_1122;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst byte_count", 32'(byte_count), 32'd0);
        check("mid rst req_ready", 32'(req_ready), 32'd0);
        check("mid rst out_byte", 32'(out_byte), 32'd0);
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Contention with both held: 0,1,0,1,0 every three cycles.
        for (int k = 0; k < 5; k++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = (k % 2 == 0) ? 8'h22 : 8'h44;
            hi = (k % 2 == 0) ? 8'h11 : 8'h33;
            check($sformatf("cont%0d ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            if (k == 3) req_valid = 2'b01;
            if (k == 4) req_valid = 2'b00;
            #1;
            check($sformatf("cont%0d no ready", k), 32'(req_ready), 32'd0);
            check($sformatf("cont%0d src", k), 32'(out_src), (k % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("cont%0d b0", k), 32'(out_byte), 32'(first_b(lo, hi)));
            @(negedge clk);
            #1;
            check($sformatf("cont%0d one-hot", k), 32'($countones(req_ready) <= 1), 32'd1);
            check($sformatf("cont%0d b1", k), 32'(out_byte), 32'(second_b(lo, hi)));
            check($sformatf("cont%0d last", k), 32'(out_last), 32'd1);
            @(negedge clk);
            #1;
        end
        exp_cnt = 16'd10;
        check("cont cnt", 32'(byte_count), 32'(exp_cnt));
        check("cont busy", 32'(busy), 32'd0);

        // Counter wrap: preload 0xFFFE, then one word from requester 1 (rr_ptr=1).
        @(negedge clk);
        force dut.byte_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.byte_count_q;
        #1;
        check("wrap preload", 32'(byte_count), 32'h0000FFFE);
        exp_cnt = 16'hFFFE;
        run_word(wr, "wrap");

        // Idle: no requests for ten cycles.
        req_valid = 2'b00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("idle busy", 32'(busy), 32'd0);
            check("idle out_valid", 32'(out_valid), 32'd0);
            check("idle req_ready", 32'(req_ready), 32'd0);
        end
        check("idle cnt", 32'(byte_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
